param_reg_resp: RTL
===================

Name: param_reg_resp

Overview:
- Responder (slave) end of the read bus used by the motor-control parameter readers: holds a bank of 32-bit parameter registers (rotation velocity, P/I/D gains, etc.).
- Serves valid/ready read requests from one read master.
- Accepts register updates from one write master, e.g. the host command decoder.
- Sits between the host-side write path and the motor_ctrl parameter readers.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; legal range 1..256, addresses 0..NUM_REGS-1.
- RESET_VALUE, 32'h0, value loaded into every register on reset.

Ports:
- clk  input  1  clock
- rstn  input  1  reset; synchronous, active-low
- r_addr  input  8  read address; master holds it stable while r_valid=1
- r_valid  input  1  read request; master holds it until handshake
- r_ready  output  1  read response valid; handshake = r_valid & r_ready
- r_data  output  32  read data; meaningful only while r_ready=1
- w_addr  input  8  write address; held while w_valid=1
- w_data  input  32  write data; held while w_valid=1
- w_valid  input  1  write request; held until handshake
- w_ready  output  1  write accept; handshake = w_valid & w_ready
- upd_pulse  output  1  one-cycle pulse on each committed in-range write
- upd_addr  output  8  address of the last committed write
- err_pulse  output  1  one-cycle pulse on any out-of-range read or write handshake

Behaviour:
- Reset: all registers set to RESET_VALUE. Outputs: r_ready=0, r_data=0, w_ready=0, upd_pulse=0, upd_addr=0, err_pulse=0. Both FSMs go to IDLE.
- Reset mid-transaction drops the transaction: no write commit, no read response.

Read FSM (states R_IDLE, R_RESP):
- R_IDLE:
  - If r_valid=1: latch data_q <= reg[r_addr], or 0 if r_addr>=NUM_REGS; latch the out-of-range flag; go to R_RESP.
  - Else stay.
- R_RESP:
  - r_ready=1, r_data=data_q, both driven from registers.
  - If r_valid=1, handshake occurs: go to R_IDLE. err_pulse=1 next cycle if the latched address was out of range.
  - If r_valid=0 (master reset/abort): go to R_IDLE silently.
- Timing: request seen at cycle t gives r_ready=1 in cycle t+1; the handshake completes in t+1 if valid is still held. Minimum two cycles per read.
- r_ready=0 and r_data=0 in R_IDLE.

Write FSM (states W_IDLE, W_ACK):
- W_IDLE: if w_valid=1, go to W_ACK.
- W_ACK:
  - w_ready=1.
  - If w_valid=1: commit reg[w_addr] <= w_data if in range, then pulse upd_pulse and update upd_addr next cycle. If out of range, drop the data and pulse err_pulse. Go to W_IDLE.
  - If w_valid=0: go to W_IDLE without commit.
- w_ready is registered and equals (state==W_ACK).

Simultaneous events:
- A read lookup in R_IDLE in the same cycle as a write commit to the same address latches the new w_data (write-through bypass).
- A read and a write to different addresses proceed independently with no stall.
- A write commit while the read FSM is in R_RESP does not alter data_q: the response returns the value latched at lookup.
- err_pulse is the OR of the read and write error sources in the same cycle.

Other rules:
- Registers are only ever written whole (32-bit); there are no byte enables.
- Upper address bits beyond the register count are never wrapped: any addr>=NUM_REGS is out of range.

Test Plan:
- Reset: hold rstn=0 for 3 cycles, then read addr 0..15 → every r_data=0. Each handshake occurs exactly 1 cycle after r_valid rises; r_ready=0 between reads.
- Write then read: write 8'h01 ← 32'h0000_1234 → w_ready high the cycle after w_valid, then upd_pulse=1 with upd_addr=8'h01. A following read of 8'h01 returns 32'h0000_1234.
- Bypass: write 8'h03 ← 32'hDEAD_BEEF committing in the same cycle the read FSM looks up 8'h03 → the read returns 32'hDEAD_BEEF, not the old value.
- Out of range: read 8'h20 with NUM_REGS=16 → r_data=0 and err_pulse=1 after the handshake. Write 8'h20 ← 32'hFFFF_FFFF → err_pulse=1, no upd_pulse, and reads of 8'h00..8'h0F are unchanged.
- Abort: raise r_valid for 1 cycle only, dropping it before r_ready → the FSM returns to R_IDLE with no err_pulse. The next full read of 8'h01 completes normally.
- Back-to-back master pattern: alternate reads of 8'h00 and gain reads of 8'h01/8'h02/8'h03 with valid re-asserted 1 cycle after each handshake, for 100 requests → every response matches the register contents and no request is lost or duplicated.

Source files
------------

// File: rtl/param_reg_resp.sv
// Motor-control parameter register bank: one read responder port and
// one write port, each with its own two-state valid/ready handshake FSM.
module param_reg_resp #(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  r_addr,
    input  logic        r_valid,
    output logic        r_ready,
    output logic [31:0] r_data,
    input  logic [7:0]  w_addr,
    input  logic [31:0] w_data,
    input  logic        w_valid,
    output logic        w_ready,
    output logic        upd_pulse,
    output logic [7:0]  upd_addr,
    output logic        err_pulse
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {R_IDLE, R_RESP} r_state_e;
    typedef enum logic {W_IDLE, W_ACK}  w_state_e;

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic [31:0] data_q, data_d;
    logic        r_ready_q, r_ready_d;
    logic        r_oor_q, r_oor_d;
    logic        w_ready_q, w_ready_d;
    logic        upd_pulse_q, upd_pulse_d;
    logic [7:0]  upd_addr_q, upd_addr_d;
    logic        err_pulse_q, err_pulse_d;

    logic          r_in_range;
    logic          w_in_range;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx;
    logic          w_commit;

    assign r_in_range = ({1'b0, r_addr} < 9'(NUM_REGS));
    assign w_in_range = ({1'b0, w_addr} < 9'(NUM_REGS));
    assign r_idx      = r_addr[AW-1:0];
    assign w_idx      = w_addr[AW-1:0];
    assign w_commit   = (w_state_q == W_ACK) && w_valid && w_in_range;

    // Next-state, register-bank update and pulse generation for both ports
    always_comb begin
        logic rd_err;
        logic wr_err;
        r_state_d   = r_state_q;
        w_state_d   = w_state_q;
        regs_d      = regs_q;
        data_d      = data_q;
        r_ready_d   = r_ready_q;
        r_oor_d     = r_oor_q;
        w_ready_d   = w_ready_q;
        upd_pulse_d = 1'b0;
        upd_addr_d  = upd_addr_q;
        rd_err      = 1'b0;
        wr_err      = 1'b0;

        // Write port; a commit is visible to a same-cycle read lookup
        unique case (w_state_q)
            W_IDLE: begin
                if (w_valid) begin
                    w_state_d = W_ACK;
                    w_ready_d = 1'b1;
                end
            end
            W_ACK: begin
                w_state_d = W_IDLE;
                w_ready_d = 1'b0;
                if (w_valid) begin
                    if (w_in_range) begin
                        regs_d[w_idx] = w_data;
                        upd_pulse_d   = 1'b1;
                        upd_addr_d    = w_addr;
                    end else begin
                        wr_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = W_IDLE;
                w_ready_d = 1'b0;
            end
        endcase

        // Read port; data is captured at lookup and held through response
        unique case (r_state_q)
            R_IDLE: begin
                if (r_valid) begin
                    r_state_d = R_RESP;
                    r_ready_d = 1'b1;
                    r_oor_d   = !r_in_range;
                    if (!r_in_range)
                        data_d = 32'h0;
                    else if (w_commit && (w_addr == r_addr))
                        data_d = w_data;
                    else
                        data_d = regs_q[r_idx];
                end
            end
            R_RESP: begin
                r_state_d = R_IDLE;
                r_ready_d = 1'b0;
                data_d    = 32'h0;
                r_oor_d   = 1'b0;
                rd_err    = r_valid && r_oor_q;
            end
            default: begin
                r_state_d = R_IDLE;
                r_ready_d = 1'b0;
                data_d    = 32'h0;
            end
        endcase

        err_pulse_d = rd_err | wr_err;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_q   <= R_IDLE;
            w_state_q   <= W_IDLE;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= RESET_VALUE;
            data_q      <= 32'h0;
            r_ready_q   <= 1'b0;
            r_oor_q     <= 1'b0;
            w_ready_q   <= 1'b0;
            upd_pulse_q <= 1'b0;
            upd_addr_q  <= 8'h0;
            err_pulse_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            w_state_q   <= w_state_d;
            regs_q      <= regs_d;
            data_q      <= data_d;
            r_ready_q   <= r_ready_d;
            r_oor_q     <= r_oor_d;
            w_ready_q   <= w_ready_d;
            upd_pulse_q <= upd_pulse_d;
            upd_addr_q  <= upd_addr_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign r_ready   = r_ready_q;
    assign r_data    = data_q;
    assign w_ready   = w_ready_q;
    assign upd_pulse = upd_pulse_q;
    assign upd_addr  = upd_addr_q;
    assign err_pulse = err_pulse_q;

endmodule
